// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//  Bundles the CPU fetch port, the CPU load/store port and the downstream
//  memory port that mem_port_arbiter sits between.
//  Modports:
//   slave  - the arbiter's view (CPU requests and mem_ack/mem_rdata in;
//            ready pulses, rdata, mem_* request fields and bus_error out)
//   master - the environment's view (CPU + memory model), directions reversed
interface mem_port_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    // load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic [31:0] d_rdata;
    // memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_error;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ack, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_error
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ack, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one single-ported, variable-latency memory between the CPU fetch
//  port and its load/store port using a req/ack handshake and a registered FSM
//  (IDLE -> IF_WAIT/D_WAIT -> RESP -> IDLE). Data wins arbitration unless fetch
//  has been passed over STARVE_LIMIT times in a row while requesting.
//  Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave: fetch port, load/store port, memory port
//  Optional feature: define MEM_TIMEOUT_EN to abandon a memory access after
//  TIMEOUT_CYCLES wait cycles without mem_ack; the granted port then gets its
//  ready pulse with rdata 32'hDEAD_BEEF and bus_error pulses alongside.
//  Without it the FSM waits on mem_ack forever and bus_error is tied low.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [3:0]  starve_q, starve_d;
    logic        bus_error_q, bus_error_d;
    logic        grant_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    // counter value during the last permitted wait cycle
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // Byte-lane bits of the request addresses never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

    // Data wins unless fetch is also waiting and has been starved out.
    assign grant_d = bus.d_req && !(bus.if_req && (starve_q == 4'(STARVE_LIMIT)));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        starve_d    = starve_q;
        bus_error_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = D_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = {bus.d_addr[31:2], 2'b00};
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                    if (bus.if_req) starve_d = starve_q + 4'd1;
`ifdef MEM_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end else if (bus.if_req) begin
                    state_d     = IF_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {bus.if_addr[31:2], 2'b00};
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    starve_d    = '0;
`ifdef MEM_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end
            IF_WAIT, D_WAIT: begin
                // mem_* fields stay put; only mem_req drops on completion.
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == IF_WAIT) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    if (state_q == IF_WAIT) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = 32'hDEAD_BEEF;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = 32'hDEAD_BEEF;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            // Ready pulse is visible here; no grant, so the requester can drop req.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            starve_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            starve_q    <= starve_d;
            bus_error_q <= bus_error_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
`ifdef MEM_TIMEOUT_EN
    assign bus.bus_error = bus_error_q;
`else
    assign bus.bus_error = 1'b0;
    logic unused_bus_error;
    assign unused_bus_error = bus_error_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//  Directed bench for mem_port_arbiter: fetch, load, store, zero-BE store,
//  simultaneous requests, starvation forcing, stray ack, async reset mid-access
//  and the timeout path (or its absence in the default build).
//  Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // expected grant order with both ports held requesting: D,D,D,D,IF,D
    logic [31:0] starve_exp [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;

        // reset state
        repeat (2) tick();
        check("rst_mem_req",   {31'd0, bus.mem_req}, 0);
        check("rst_mem_addr",  bus.mem_addr, 0);
        check("rst_mem_we_be", {27'd0, bus.mem_we, bus.mem_be}, 0);
        check("rst_readies",   {30'd0, bus.if_ready, bus.d_ready}, 0);
        check("rst_if_rdata",  bus.if_rdata, 0);
        check("rst_d_rdata",   bus.d_rdata, 0);
        check("rst_bus_error", {31'd0, bus.bus_error}, 0);
        rst_n = 1;
        tick();

        // fetch only, ack at cycle 3
        bus.if_req = 1; bus.if_addr = 32'h0000_0043;
        tick();                                  // cycle 1
        check("f_mem_req",  {31'd0, bus.mem_req}, 1);
        check("f_mem_addr", bus.mem_addr, 32'h40);
        check("f_mem_be",   {28'd0, bus.mem_be}, 32'hF);
        check("f_mem_we",   {31'd0, bus.mem_we}, 0);
        tick();                                  // cycle 2
        tick();                                  // cycle 3
        bus.mem_ack = 1; bus.mem_rdata = 32'h2402_0005;
        check("f_no_early_ready", {31'd0, bus.if_ready}, 0);
        tick();                                  // cycle 4
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("f_if_ready", {31'd0, bus.if_ready}, 1);
        check("f_if_rdata", bus.if_rdata, 32'h2402_0005);
        check("f_mem_req_drop", {31'd0, bus.mem_req}, 0);
        check("f_no_d_ready", {31'd0, bus.d_ready}, 0);
        bus.if_req = 0;
        tick();
        check("f_ready_pulse_1cyc", {31'd0, bus.if_ready}, 0);

        // load, 1-cycle ack
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h206; bus.d_be = 4'hF;
        tick();
        check("ld_mem_addr", bus.mem_addr, 32'h204);
        check("ld_mem_we", {31'd0, bus.mem_we}, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("ld_d_ready", {31'd0, bus.d_ready}, 1);
        check("ld_d_rdata", bus.d_rdata, 32'h1234_5678);
        check("ld_if_rdata_kept", bus.if_rdata, 32'h2402_0005);
        bus.d_req = 0;
        tick();

        // store, 1-cycle ack; d_rdata must not change
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h102; bus.d_wdata = 32'hAB00_0000; bus.d_be = 4'b1000;
        tick();                                  // cycle 1
        check("st_mem_req",   {31'd0, bus.mem_req}, 1);
        check("st_mem_addr",  bus.mem_addr, 32'h100);
        check("st_mem_we",    {31'd0, bus.mem_we}, 1);
        check("st_mem_wdata", bus.mem_wdata, 32'hAB00_0000);
        check("st_mem_be",    {28'd0, bus.mem_be}, 32'h8);
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();                                  // cycle 2
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("st_d_ready", {31'd0, bus.d_ready}, 1);
        check("st_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        bus.d_req = 0;
        tick();

        // zero-byte-enable store is still issued
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h108; bus.d_be = 4'b0000;
        tick();
        check("be0_mem_req", {31'd0, bus.mem_req}, 1);
        check("be0_mem_be",  {28'd0, bus.mem_be}, 0);
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        check("be0_d_ready", {31'd0, bus.d_ready}, 1);
        bus.d_req = 0; bus.d_we = 0;
        tick();

        // simultaneous requests: data first, then fetch, no repeat of data
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h208; bus.d_be = 4'hF;
        bus.if_req = 1; bus.if_addr = 32'h10;
        tick();
        check("both_first_is_data", bus.mem_addr, 32'h208);
        bus.mem_ack = 1; bus.mem_rdata = 32'h55;
        tick();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("both_d_ready",  {30'd0, bus.d_ready, bus.if_ready}, 32'h2);
        bus.d_req = 0;
        tick();                                  // IDLE
        check("both_idle_no_req", {31'd0, bus.mem_req}, 0);
        tick();
        check("both_then_fetch_req", {31'd0, bus.mem_req}, 1);
        check("both_then_fetch_addr", bus.mem_addr, 32'h10);
        bus.mem_ack = 1; bus.mem_rdata = 32'h77;
        tick();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("both_if_ready", {30'd0, bus.d_ready, bus.if_ready}, 32'h1);
        check("both_if_rdata", bus.if_rdata, 32'h77);
        bus.if_req = 0;
        tick();

        // starvation: both held high, fetch forced after 4 data grants
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        bus.if_req = 1; bus.if_addr = 32'h300;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("starve_grant%0d", i), bus.mem_addr, starve_exp[i]);
            bus.mem_ack = 1; bus.mem_rdata = 32'(i);
            tick();
            bus.mem_ack = 0; bus.mem_rdata = 0;
            tick();
        end
        bus.d_req = 0; bus.if_req = 0;
        tick();

        // stray ack in IDLE is ignored
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        tick();
        check("stray_ack_no_ready", {30'd0, bus.d_ready, bus.if_ready}, 0);
        check("stray_ack_no_req", {31'd0, bus.mem_req}, 0);

        // async reset while in D_WAIT
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        tick();
        check("rstmid_req_before", {31'd0, bus.mem_req}, 1);
        rst_n = 0;
        #1;
        check("rstmid_req_async_drop", {31'd0, bus.mem_req}, 0);
        bus.d_req = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid_no_ready", {30'd0, bus.d_ready, bus.mem_req}, 0);
        end
        check("rstmid_d_rdata_cleared", bus.d_rdata, 0);
        bus.if_req = 1; bus.if_addr = 32'h44;
        tick();
        check("rstmid_idle_grant_addr", bus.mem_addr, 32'h44);
        bus.mem_ack = 1; bus.mem_rdata = 32'h99;
        tick();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        check("rstmid_if_ready", {31'd0, bus.if_ready}, 1);
        bus.if_req = 0;
        tick();

        // memory never acks
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
        tick();                                  // wait cycle 1
        check("tmo_req", {31'd0, bus.mem_req}, 1);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin        // wait cycles 2..8
            tick();
            check("tmo_no_early", {30'd0, bus.d_ready, bus.bus_error}, 0);
        end
        tick();
        check("tmo_pulse", {30'd0, bus.d_ready, bus.bus_error}, 32'h3);
        check("tmo_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        check("tmo_req_drop", {31'd0, bus.mem_req}, 0);
        bus.d_req = 0;
        tick();
        check("tmo_pulse_1cyc", {31'd0, bus.bus_error}, 0);
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("notmo_quiet", {30'd0, bus.d_ready, bus.bus_error}, 0);
        end
        check("notmo_req_held", {31'd0, bus.mem_req}, 1);
        bus.d_req = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
